// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands whole messages from num_req requesters to a UART TX FIFO.
// Optional idle-grant timeout (and timeout_err port) enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int data_bits      = 8,
  parameter int num_req        = 4,
  parameter int timeout_cycles = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [num_req-1:0]           req_valid,
  input  logic [num_req*data_bits-1:0] req_data,
  input  logic [num_req-1:0]           req_last,
  output logic [num_req-1:0]           req_ready,
  input  logic                         tx_full,
  output logic                         wr_en,
  output logic [data_bits-1:0]         data_in,
  output logic [num_req-1:0]           grant,
  output logic                         busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);

  localparam int idx_w = (num_req > 1) ? $clog2(num_req) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state_r, state_s;
  logic [idx_w-1:0]     owner_r, owner_s;
  logic [idx_w-1:0]     ptr_r, ptr_s;
  logic [num_req-1:0]   grant_r, grant_s;
  logic                 busy_r;
  logic                 pick_found_s;
  logic [idx_w-1:0]     pick_idx_s;
  logic [idx_w-1:0]     cand_idx_s;
  int                   cand_s;
  logic [data_bits-1:0] own_data_s;
  logic                 own_valid_s;
  logic                 own_last_s;
  logic                 beat_s;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]          idle_cnt_r;
  logic                 idle_s;
  logic                 timeout_hit_s;
  logic                 timeout_err_r;
`endif

  // Search for the next valid requester, starting just after the previous owner.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = 0;
    cand_idx_s   = '0;
    for (int k = 1; k <= num_req; k++) begin
      cand_s     = (int'(ptr_r) + k) % num_req;
      cand_idx_s = idx_w'(cand_s);
      if (!pick_found_s && req_valid[cand_idx_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_idx_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // The registered one-hot grant doubles as the select for the owner's lanes.
  always_comb begin
    own_data_s = '0;
    for (int i = 0; i < num_req; i++) begin
      own_data_s = own_data_s | (req_data[i*data_bits +: data_bits] & {data_bits{grant_r[i]}});
    end
  end

  assign own_valid_s = |(req_valid & grant_r);
  assign own_last_s  = |(req_last & grant_r);
  assign beat_s      = own_valid_s & ~tx_full;

  assign req_ready = grant_r & {num_req{~tx_full}};
  assign wr_en     = beat_s;
  assign data_in   = own_data_s;
  assign grant     = grant_r;
  assign busy      = busy_r;

  // Next-state, owner and round-robin pointer selection.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_s = GRANT;
          owner_s = pick_idx_s;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (beat_s && own_last_s) begin
          state_s = IDLE;
          ptr_s   = owner_r;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (timeout_hit_s) begin
          state_s = IDLE;
          ptr_s   = owner_r;
`endif
        end else begin
          state_s = GRANT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    grant_s = '0;
    if (state_s == GRANT) begin
      grant_s[owner_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // State register; ptr resets to the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      owner_r <= '0;
      ptr_r   <= idx_w'(num_req - 1);
      grant_r <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      grant_r <= grant_s;
      busy_r  <= (state_s == GRANT);
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  assign idle_s        = (state_r == GRANT) & ~own_valid_s & ~tx_full;
  assign timeout_hit_s = idle_s & (idle_cnt_r == 16'(timeout_cycles - 1));
  assign timeout_err   = timeout_err_r;

  // Idle-grant counter: frozen while the FIFO is full, cleared by any beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_r    <= 16'd0;
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= timeout_hit_s;
      if ((state_r != GRANT) || beat_s || timeout_hit_s) begin
        idle_cnt_r <= 16'd0;
      end else if (idle_s) begin
        idle_cnt_r <= idle_cnt_r + 16'd1;
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// message traffic compared against a message-level round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic            tx_full, wr_en, busy;
  logic [DW-1:0]   data_in;
`ifdef UART_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  uart_tx_arbiter #(.data_bits(DW), .num_req(N), .timeout_cycles(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full), .wr_en(wr_en),
    .data_in(data_in), .grant(grant), .busy(busy)
`ifdef UART_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic          wr_en;
    logic [DW-1:0] data;
    logic [N-1:0]  ready;
    logic          busy;
    logic          terr;
  } obs_t;

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
  } exp_t;

  obs_t          obs_q[$];
  logic [DW:0]   msg_q[N][$];   // {last, data} per pending byte
  exp_t          exp_q[$];
  int            wr_own[$];
  logic [DW-1:0] wr_dat[$];
  int            wr_cyc[$];
  logic [N-1:0]  acc_r, valid_mask;
  logic          force_full, rand_full;
  int            errors, checks, m_ptr;

  function automatic int owner_of(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Model: messages are served whole, owner chosen round-robin from the previous owner.
  task automatic model_build();
    logic [DW:0] rem[N][$];
    logic [DW:0] b;
    int pick;
    exp_t e;
    for (int i = 0; i < N; i++) rem[i] = msg_q[i];
    exp_q.delete();
    pick = 0;
    while (pick >= 0) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (pick < 0 && rem[c].size() > 0) pick = c;
      end
      if (pick >= 0) begin
        do begin
          b = rem[pick].pop_front();
          e.owner = pick;
          e.data  = b[DW-1:0];
          exp_q.push_back(e);
        end while (!b[DW] && rem[pick].size() > 0);
        m_ptr = pick;
      end
    end
  endtask

  task automatic step();
    obs_t o;
    @(negedge clk);
    for (int i = 0; i < N; i++) if (acc_r[i] && msg_q[i].size() > 0) void'(msg_q[i].pop_front());
    tx_full   = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (msg_q[i].size() > 0 && !valid_mask[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = msg_q[i][0][DW-1:0];
        req_last[i]           = msg_q[i][0][DW];
      end
    end
    #1;
    o.grant = grant; o.wr_en = wr_en; o.data = data_in; o.ready = req_ready; o.busy = busy;
`ifdef UART_ARB_TIMEOUT_EN
    o.terr = timeout_err;
`else
    o.terr = 1'b0;
`endif
    obs_q.push_back(o);
    acc_r = req_ready & req_valid;
    checks++;
    if (!$onehot0(grant) || busy !== (grant != '0)) begin
      errors++; $display("FAIL grant_busy: grant=%b busy=%b, required one-hot grant with busy=|grant", grant, busy);
    end
    checks++;
    if (req_ready !== (grant & {N{~tx_full}})) begin
      errors++; $display("FAIL ready_rule: ready=%b, required %b", req_ready, grant & {N{~tx_full}});
    end
    checks++;
    if (wr_en !== ((|(grant & req_valid)) & ~tx_full)) begin
      errors++; $display("FAIL wr_en_rule: wr_en=%b, required %b", wr_en, (|(grant & req_valid)) & ~tx_full);
    end
  endtask

  task automatic run_until_idle(input int max_cyc, input string tag);
    int n, rem;
    n = 0;
    rem = 0;
    do begin
      step();
      n++;
      rem = 0;
      for (int i = 0; i < N; i++) rem += msg_q[i].size() - (acc_r[i] ? 1 : 0);
    end while ((rem > 0 || grant != '0) && n < max_cyc);
    checks++;
    if (rem > 0 || grant != '0) begin
      errors++; $display("FAIL %s_drain: pending=%0d grant=%b after %0d cycles, required drained", tag, rem, grant, n);
    end
  endtask

  task automatic collect_writes();
    wr_own.delete(); wr_dat.delete(); wr_cyc.delete();
    foreach (obs_q[c]) begin
      if (obs_q[c].wr_en) begin
        wr_own.push_back(owner_of(obs_q[c].grant));
        wr_dat.push_back(obs_q[c].data);
        wr_cyc.push_back(c);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) msg_q[i].delete();
    acc_r = '0; valid_mask = '0; req_valid = '0; req_last = '0; req_data = '0; tx_full = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_ptr = N - 1;
    obs_q.delete();
  endtask

  task automatic push_msg(input int r, input logic [DW-1:0] b0, input int len);
    logic [DW:0] v;
    for (int k = 0; k < len; k++) begin
      v = {(k == len - 1) ? 1'b1 : 1'b0, b0 + DW'(k)};
      msg_q[r].push_back(v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_full = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    #2 reset = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b required 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    req_valid = '1;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b required 0000", req_ready); end
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0000 || wr_en !== 1'b0) begin errors++; $display("FAIL reset_hold: grant=%b wr_en=%b required 0000/0", grant, wr_en); end
    req_valid = '0;
    reset = 1'b1;
    m_ptr = N - 1;
  endtask

  task automatic test_single_message();
    logic [N-1:0]  eg[5];
    logic [DW-1:0] ed[3];
    eg = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    ed = '{8'h9A, 8'h6B, 8'hC8};
    obs_q.delete();
    msg_q[0].push_back({1'b0, 8'h9A});
    msg_q[0].push_back({1'b0, 8'h6B});
    msg_q[0].push_back({1'b1, 8'hC8});
    repeat (6) step();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs_q[c].grant !== eg[c] || obs_q[c].wr_en !== ((c >= 1 && c <= 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL single_cycle%0d: grant=%b wr_en=%b required %b/%b", c, obs_q[c].grant, obs_q[c].wr_en, eg[c], (c >= 1 && c <= 3));
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if (obs_q[c].data !== ed[c-1]) begin errors++; $display("FAIL single_data%0d: got %h required %h", c, obs_q[c].data, ed[c-1]); end
      end
    end
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    int eo[5];
    eo = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < N; i++) begin
      push_msg(i, DW'(8'h10 * i), 1);
      push_msg(i, DW'(8'h10 * i + 8'h80), 1);
    end
    model_build();
    run_until_idle(100, "rr");
    collect_writes();
    checks++;
    if (wr_own.size() !== exp_q.size()) begin errors++; $display("FAIL rr_count: got %0d writes required %0d", wr_own.size(), exp_q.size()); end
    for (int k = 0; k < wr_own.size() && k < exp_q.size(); k++) begin
      checks++;
      if (wr_own[k] !== exp_q[k].owner || wr_dat[k] !== exp_q[k].data) begin
        errors++; $display("FAIL rr_write%0d: owner=%0d data=%h required %0d/%h", k, wr_own[k], wr_dat[k], exp_q[k].owner, exp_q[k].data);
      end
    end
    for (int k = 0; k < 5 && k < wr_own.size(); k++) begin
      checks++;
      if (wr_own[k] !== eo[k]) begin errors++; $display("FAIL rr_order%0d: got %0d required %0d", k, wr_own[k], eo[k]); end
      if (k > 0) begin
        checks++;
        if (wr_cyc[k] - wr_cyc[k-1] !== 2) begin errors++; $display("FAIL rr_gap%0d: got %0d cycles required 2", k, wr_cyc[k] - wr_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_tx_full();
    int n, f0, cnt35;
    obs_q.delete();
    force_full = 1'b0;
    msg_q[2].push_back({1'b0, 8'h12});
    msg_q[2].push_back({1'b0, 8'h35});
    msg_q[2].push_back({1'b1, 8'h77});
    n = 0;
    do begin step(); n++; end while (!obs_q[$].wr_en && n < 10);
    force_full = 1'b1;
    f0 = obs_q.size();
    repeat (5) step();
    force_full = 1'b0;
    run_until_idle(20, "full");
    for (int c = f0; c < f0 + 5; c++) begin
      checks++;
      if (obs_q[c].wr_en !== 1'b0 || obs_q[c].ready[2] !== 1'b0 || obs_q[c].grant !== 4'b0100) begin
        errors++; $display("FAIL full_stall%0d: wr_en=%b ready2=%b grant=%b required 0/0/0100", c - f0, obs_q[c].wr_en, obs_q[c].ready[2], obs_q[c].grant);
      end
    end
    checks++;
    if (obs_q[f0+5].wr_en !== 1'b1 || obs_q[f0+5].data !== 8'h35) begin
      errors++; $display("FAIL full_resume: wr_en=%b data=%h required 1/35", obs_q[f0+5].wr_en, obs_q[f0+5].data);
    end
    collect_writes();
    cnt35 = 0;
    foreach (wr_dat[k]) if (wr_dat[k] == 8'h35) cnt35++;
    checks++;
    if (wr_dat.size() !== 3 || cnt35 !== 1) begin errors++; $display("FAIL full_writes: %0d writes with %0d of 35, required 3 and 1", wr_dat.size(), cnt35); end
  endtask

  task automatic test_hold_grant();
    int a3;
    obs_q.delete();
    force_full = 1'b0;
    msg_q[1].push_back({1'b0, 8'hA1});
    msg_q[1].push_back({1'b0, 8'hA2});
    msg_q[1].push_back({1'b1, 8'hA3});
    repeat (2) step();
    checks++;
    if (obs_q[1].grant !== 4'b0010 || obs_q[1].data !== 8'hA1) begin errors++; $display("FAIL hold_start: grant=%b data=%h required 0010/a1", obs_q[1].grant, obs_q[1].data); end
    msg_q[3].push_back({1'b1, 8'hB1});
    valid_mask[1] = 1'b1;
    repeat (3) step();
    for (int c = 2; c < 5; c++) begin
      checks++;
      if (obs_q[c].grant !== 4'b0010 || obs_q[c].wr_en !== 1'b0) begin errors++; $display("FAIL hold_gap%0d: grant=%b wr_en=%b required 0010/0", c, obs_q[c].grant, obs_q[c].wr_en); end
    end
    valid_mask = '0;
    run_until_idle(30, "hold");
    a3 = -1;
    foreach (obs_q[c]) if (obs_q[c].wr_en && obs_q[c].data == 8'hA3 && a3 < 0) a3 = c;
    checks++;
    if (a3 < 0 || a3 + 2 >= obs_q.size()) begin
      errors++; $display("FAIL hold_last: last beat index %0d, required a3 write with two cycles after", a3);
    end else begin
      for (int c = 0; c <= a3; c++) begin
        checks++;
        if (obs_q[c].grant[3] !== 1'b0) begin errors++; $display("FAIL hold_no_r3_%0d: grant=%b required bit3 low", c, obs_q[c].grant); end
      end
      checks++;
      if (obs_q[a3+1].grant !== 4'b0000 || obs_q[a3+2].grant !== 4'b1000 || obs_q[a3+2].data !== 8'hB1) begin
        errors++; $display("FAIL hold_handover: grants %b,%b data %h required 0000,1000 b1", obs_q[a3+1].grant, obs_q[a3+2].grant, obs_q[a3+2].data);
      end
    end
  endtask

  task automatic test_random();
    int nmsg, len, total;
    apply_reset();
    rand_full = 1'b1;
    for (int round = 0; round < 4; round++) begin
      total = 0;
      for (int i = 0; i < N; i++) begin
        nmsg = $urandom_range(0, 3);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) msg_q[i].push_back({(k == len - 1) ? 1'b1 : 1'b0, DW'($urandom)});
          total++;
        end
      end
      if (total == 0) push_msg(0, DW'($urandom), 2);
      model_build();
      obs_q.delete();
      run_until_idle(2000, "rand");
      collect_writes();
      checks++;
      if (wr_own.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count%0d: got %0d writes required %0d", round, wr_own.size(), exp_q.size()); end
      for (int k = 0; k < wr_own.size() && k < exp_q.size(); k++) begin
        checks++;
        if (wr_own[k] !== exp_q[k].owner || wr_dat[k] !== exp_q[k].data) begin
          errors++; $display("FAIL rand_write%0d_%0d: owner=%0d data=%h required %0d/%h", round, k, wr_own[k], wr_dat[k], exp_q[k].owner, exp_q[k].data);
        end
      end
    end
    rand_full = 1'b0;
  endtask

  task automatic test_reset_mid_message();
    int n;
    obs_q.delete();
    force_full = 1'b0;
    push_msg(0, 8'hC1, 3);
    n = 0;
    do begin step(); n++; end while (!obs_q[$].wr_en && n < 10);
    @(negedge clk);
    tx_full = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: wr_en=%b grant=%b busy=%b required 0/0000/0", wr_en, grant, busy);
    end
    for (int i = 0; i < N; i++) msg_q[i].delete();
    acc_r = '0;
    req_valid = '0;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (wr_en !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL mid_reset_hold: wr_en=%b grant=%b required 0/0000", wr_en, grant); end
    end
    reset = 1'b1;
    m_ptr = N - 1;
    msg_q[1].push_back({1'b1, 8'hD1});
    msg_q[0].push_back({1'b1, 8'hE0});
    model_build();
    obs_q.delete();
    run_until_idle(20, "restart");
    collect_writes();
    checks++;
    if (wr_own.size() !== 2 || wr_own[0] !== 0 || wr_dat[0] !== 8'hE0 || wr_own[1] !== exp_q[1].owner || wr_dat[1] !== exp_q[1].data) begin
      errors++; $display("FAIL restart_order: %0d writes, first owner %0d, required 2 writes starting at requester 0", wr_own.size(), (wr_own.size() > 0) ? wr_own[0] : -1);
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    msg_q[0].push_back({1'b0, 8'h01});
    msg_q[0].push_back({1'b1, 8'h02});
    msg_q[1].push_back({1'b1, 8'h55});
    repeat (2) step();
    valid_mask[0] = 1'b1;
    repeat (18) step();
    for (int c = 2; c < 18; c++) begin
      checks++;
      if (obs_q[c].terr !== 1'b0 || obs_q[c].grant !== 4'b0001 || obs_q[c].wr_en !== 1'b0) begin
        errors++; $display("FAIL to_wait%0d: terr=%b grant=%b wr_en=%b required 0/0001/0", c, obs_q[c].terr, obs_q[c].grant, obs_q[c].wr_en);
      end
    end
    checks++;
    if (obs_q[18].terr !== 1'b1 || obs_q[18].grant !== 4'b0000) begin errors++; $display("FAIL to_pulse: terr=%b grant=%b required 1/0000", obs_q[18].terr, obs_q[18].grant); end
    checks++;
    if (obs_q[19].terr !== 1'b0 || obs_q[19].grant !== 4'b0010 || obs_q[19].data !== 8'h55) begin
      errors++; $display("FAIL to_handover: terr=%b grant=%b data=%h required 0/0010/55", obs_q[19].terr, obs_q[19].grant, obs_q[19].data);
    end
    valid_mask = '0;
    run_until_idle(30, "to");
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; m_ptr = N - 1;
    acc_r = '0; valid_mask = '0; force_full = 1'b0; rand_full = 1'b0;
    test_reset();
    test_single_message();
    test_round_robin();
    test_tx_full();
    test_hold_grant();
    test_random();
    test_reset_mid_message();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
